// File: rtl/sd_cmd_pkg.sv
// Shared types and constants for the SD command sequencer: FSM states, owner encoding,
// command indices and the APP_CMD status bit position.
package sd_cmd_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_ISSUE, ST_WAIT, ST_RACK, ST_CACK, ST_NEXT, ST_FINISH
  } state_e;

  typedef enum logic {
    OWN_H = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam logic [5:0] CMD55_INDEX = 6'd55;
  localparam logic [5:0] CMD12_INDEX = 6'd12;
  localparam int         APP_CMD_BIT = 5;
endpackage

// File: rtl/sd_cmd_timer.sv
// Command watchdog: clear/enable counter that saturates and flags terminal count
// at TIMEOUT_CYCLES-1.
module sd_cmd_timer #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] count_q, count_d;

  assign tc = (count_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && !tc) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/sd_cmd_sequencer.sv
// SD CMD-block front end: arbitrates host/data-engine requests, inserts CMD55 for ACMDs,
// runs the response/completion handshakes. Optional timeout retry: SD_CMD_RETRY_EN.
module sd_cmd_sequencer
  import sd_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int RETRY_MAX      = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         h_req,
  input  logic [5:0]   h_index,
  input  logic [31:0]  h_arg,
  input  logic         h_app,
  input  logic         h_no_resp,
  output logic         h_done,
  output logic         h_err,
  input  logic         d_req,
  input  logic [5:0]   d_index,
  input  logic [31:0]  d_arg,
  input  logic         d_no_resp,
  output logic         d_done,
  output logic         d_err,
  input  logic [15:0]  rca,
  output logic [127:0] resp_data,
  output logic         busy,
  output logic         new_command,
  output logic [5:0]   cmd_index,
  output logic [31:0]  cmd_argument,
  output logic         timeout_enable,
  output logic         no_response,
  input  logic [127:0] response,
  input  logic         enable_response,
  output logic         ack_response,
  input  logic         command_complete,
  input  logic         enable_command_complete,
  output logic         ack_command_complete
);
  state_e         state_q, state_d;
  owner_e         owner_q, owner_d;
  logic [5:0]     cmd_index_q, cmd_index_d, real_index_q, real_index_d;
  logic [31:0]    cmd_arg_q, cmd_arg_d, real_arg_q, real_arg_d;
  logic           no_resp_q, no_resp_d, real_no_resp_q, real_no_resp_d;
  logic           app_q, app_d, app_stage_q, app_stage_d, resp_done_q, resp_done_d;
  logic [127:0]   resp_data_q, resp_data_d;
  logic           new_command_q, new_command_d, timeout_en_q, timeout_en_d;
  logic           ack_resp_q, ack_resp_d, ack_cc_q, ack_cc_d;
  logic           h_done_q, h_done_d, h_err_q, h_err_d, d_done_q, d_done_d, d_err_q, d_err_d;
  logic           go_finish, fin_err, tc, unused_ok;

`ifdef SD_CMD_RETRY_EN
  localparam int RETRY_W = 8;
  logic [RETRY_W-1:0] retry_q, retry_d;
  assign unused_ok = command_complete;
`else
  assign unused_ok = command_complete ^ (RETRY_MAX > 0);
`endif

  sd_cmd_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clock (clock),
    .reset (reset),
    .clr   (state_q == ST_ISSUE),
    .en    (state_q == ST_WAIT || state_q == ST_RACK),
    .tc    (tc)
  );

  assign busy                 = (state_q != ST_IDLE);
  assign new_command          = new_command_q;
  assign cmd_index            = cmd_index_q;
  assign cmd_argument         = cmd_arg_q;
  assign no_response          = no_resp_q;
  assign timeout_enable       = timeout_en_q;
  assign ack_response         = ack_resp_q;
  assign ack_command_complete = ack_cc_q;
  assign resp_data            = resp_data_q;
  assign h_done               = h_done_q;
  assign h_err                = h_err_q;
  assign d_done               = d_done_q;
  assign d_err                = d_err_q;

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    cmd_index_d    = cmd_index_q;
    cmd_arg_d      = cmd_arg_q;
    no_resp_d      = no_resp_q;
    real_index_d   = real_index_q;
    real_arg_d     = real_arg_q;
    real_no_resp_d = real_no_resp_q;
    app_d          = app_q;
    app_stage_d    = app_stage_q;
    resp_done_d    = resp_done_q;
    resp_data_d    = resp_data_q;
    timeout_en_d   = timeout_en_q;
    ack_resp_d     = ack_resp_q;
    ack_cc_d       = ack_cc_q;
    new_command_d  = 1'b0;
    h_done_d       = 1'b0;
    h_err_d        = 1'b0;
    d_done_d       = 1'b0;
    d_err_d        = 1'b0;
    go_finish      = 1'b0;
    fin_err        = 1'b0;
`ifdef SD_CMD_RETRY_EN
    retry_d        = retry_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // Data engine has fixed priority; an ACMD starts with its CMD55 prefix.
        if (d_req) begin
          owner_d        = OWN_D;
          real_index_d   = d_index;
          real_arg_d     = d_arg;
          real_no_resp_d = d_no_resp;
          app_d          = 1'b0;
          app_stage_d    = 1'b0;
          cmd_index_d    = d_index;
          cmd_arg_d      = d_arg;
          no_resp_d      = d_no_resp;
          state_d        = ST_ISSUE;
        end else if (h_req) begin
          owner_d        = OWN_H;
          real_index_d   = h_index;
          real_arg_d     = h_arg;
          real_no_resp_d = h_no_resp;
          app_d          = h_app;
          app_stage_d    = h_app;
          cmd_index_d    = h_app ? CMD55_INDEX : h_index;
          cmd_arg_d      = h_app ? {rca, 16'h0000} : h_arg;
          no_resp_d      = h_app ? 1'b0 : h_no_resp;
          state_d        = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        new_command_d = 1'b1;
        timeout_en_d  = 1'b1;
        resp_done_d   = 1'b0;
        state_d       = ST_WAIT;
      end
      ST_WAIT: begin
        if (!no_resp_q && !resp_done_q && enable_response) begin
          resp_data_d = response;
          ack_resp_d  = 1'b1;
          state_d     = ST_RACK;
        end else if (enable_command_complete && (no_resp_q || resp_done_q)) begin
          ack_cc_d = 1'b1;
          state_d  = ST_CACK;
        end else if (tc) begin
`ifdef SD_CMD_RETRY_EN
          if (retry_q < RETRY_W'(RETRY_MAX)) begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = ST_ISSUE;
            if (app_q) begin
              cmd_index_d = CMD55_INDEX;
              cmd_arg_d   = {rca, 16'h0000};
              no_resp_d   = 1'b0;
              app_stage_d = 1'b1;
            end
          end else begin
            go_finish = 1'b1;
            fin_err   = 1'b1;
          end
`else
          go_finish = 1'b1;
          fin_err   = 1'b1;
`endif
        end
      end
      ST_RACK: begin
        if (!enable_response) begin
          ack_resp_d  = 1'b0;
          resp_done_d = 1'b1;
          state_d     = ST_WAIT;
        end
      end
      ST_CACK: begin
        if (!enable_command_complete) begin
          ack_cc_d = 1'b0;
          state_d  = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (app_stage_q && resp_data_q[APP_CMD_BIT]) begin
          cmd_index_d = real_index_q;
          cmd_arg_d   = real_arg_q;
          no_resp_d   = real_no_resp_q;
          app_stage_d = 1'b0;
          state_d     = ST_ISSUE;
        end else begin
          go_finish = 1'b1;
          fin_err   = app_stage_q;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Done/err are registered on entry so they are visible during FINISH.
    if (go_finish) begin
      state_d      = ST_FINISH;
      timeout_en_d = 1'b0;
      h_done_d     = (owner_q == OWN_H);
      d_done_d     = (owner_q == OWN_D);
      h_err_d      = (owner_q == OWN_H) && fin_err;
      d_err_d      = (owner_q == OWN_D) && fin_err;
`ifdef SD_CMD_RETRY_EN
      retry_d      = '0;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      owner_q        <= OWN_H;
      cmd_index_q    <= '0;
      cmd_arg_q      <= '0;
      no_resp_q      <= 1'b0;
      real_index_q   <= '0;
      real_arg_q     <= '0;
      real_no_resp_q <= 1'b0;
      app_q          <= 1'b0;
      app_stage_q    <= 1'b0;
      resp_done_q    <= 1'b0;
      resp_data_q    <= '0;
      new_command_q  <= 1'b0;
      timeout_en_q   <= 1'b0;
      ack_resp_q     <= 1'b0;
      ack_cc_q       <= 1'b0;
      h_done_q       <= 1'b0;
      h_err_q        <= 1'b0;
      d_done_q       <= 1'b0;
      d_err_q        <= 1'b0;
`ifdef SD_CMD_RETRY_EN
      retry_q        <= '0;
`endif
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      cmd_index_q    <= cmd_index_d;
      cmd_arg_q      <= cmd_arg_d;
      no_resp_q      <= no_resp_d;
      real_index_q   <= real_index_d;
      real_arg_q     <= real_arg_d;
      real_no_resp_q <= real_no_resp_d;
      app_q          <= app_d;
      app_stage_q    <= app_stage_d;
      resp_done_q    <= resp_done_d;
      resp_data_q    <= resp_data_d;
      new_command_q  <= new_command_d;
      timeout_en_q   <= timeout_en_d;
      ack_resp_q     <= ack_resp_d;
      ack_cc_q       <= ack_cc_d;
      h_done_q       <= h_done_d;
      h_err_q        <= h_err_d;
      d_done_q       <= d_done_d;
      d_err_q        <= d_err_d;
`ifdef SD_CMD_RETRY_EN
      retry_q        <= retry_d;
`endif
    end
  end
endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Scoreboard bench for sd_cmd_sequencer: a CMD-block model answers commands, monitors record
// issued commands and done pulses, and each scenario compares them with its expectations.
module tb_sd_cmd_sequencer;
  import sd_cmd_pkg::*;

  localparam int TIMEOUT_CYCLES = 16;
  localparam int RETRY_MAX      = 2;
`ifdef SD_CMD_RETRY_EN
  localparam int EXP_PULSES = RETRY_MAX + 1;
  localparam int EXP_SPAN   = (RETRY_MAX * (TIMEOUT_CYCLES + 1)) + TIMEOUT_CYCLES;
`else
  localparam int EXP_PULSES = 1;
  localparam int EXP_SPAN   = TIMEOUT_CYCLES;
`endif
  localparam logic [127:0] RESP_900 = 128'h0000_0000_0000_0000_0000_0000_0000_0900;
  localparam logic [127:0] RESP_920 = 128'h0000_0000_0000_0000_0000_0000_0000_0920;

  typedef struct packed { logic [5:0] idx; logic [31:0] arg; logic nr; } cmd_t;
  typedef struct packed { logic own_d; logic err; logic chk; logic [127:0] resp; } done_t;

  logic clock, reset;
  logic h_req, h_app, h_no_resp, h_done, h_err;
  logic [5:0] h_index, d_index, cmd_index;
  logic [31:0] h_arg, d_arg, cmd_argument;
  logic d_req, d_no_resp, d_done, d_err;
  logic [15:0] rca;
  logic [127:0] resp_data, response;
  logic busy, new_command, timeout_enable, no_response;
  logic enable_response, ack_response, command_complete;
  logic enable_command_complete, ack_command_complete;

  int checks = 0;
  int failures = 0;
  int model_mode = 0;
  logic [127:0] model_resp = RESP_900;
  int model_fault = 0;
  bit nr_ack_seen = 0;
  cmd_t exp_cmd_q[$], obs_cmd_q[$];
  done_t exp_done_q[$], obs_done_q[$];
  cmd_t mon_c;
  done_t mon_d;
  bit mon_nr, mon_ok, mon_skip;

  sd_cmd_sequencer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .RETRY_MAX(RETRY_MAX)) dut (
    .clock(clock), .reset(reset),
    .h_req(h_req), .h_index(h_index), .h_arg(h_arg), .h_app(h_app), .h_no_resp(h_no_resp),
    .h_done(h_done), .h_err(h_err),
    .d_req(d_req), .d_index(d_index), .d_arg(d_arg), .d_no_resp(d_no_resp),
    .d_done(d_done), .d_err(d_err),
    .rca(rca), .resp_data(resp_data), .busy(busy),
    .new_command(new_command), .cmd_index(cmd_index), .cmd_argument(cmd_argument),
    .timeout_enable(timeout_enable), .no_response(no_response),
    .response(response), .enable_response(enable_response), .ack_response(ack_response),
    .command_complete(command_complete), .enable_command_complete(enable_command_complete),
    .ack_command_complete(ack_command_complete)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // CMD-block model: waits for an ack level, bounded.
  task automatic model_wait_ack(input bit cc, input bit level, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if ((cc ? ack_command_complete : ack_response) === level) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) model_fault++;
  endtask

  initial begin
    enable_response = 1'b0;
    enable_command_complete = 1'b0;
    command_complete = 1'b0;
    response = '0;
    forever begin
      @(negedge clock);
      if (reset === 1'b1 && new_command === 1'b1) begin
        mon_c.idx = cmd_index;
        mon_c.arg = cmd_argument;
        mon_c.nr  = no_response;
        obs_cmd_q.push_back(mon_c);
        mon_nr = no_response;
        mon_skip = 1'b0;
        if (model_mode != 1) begin
          repeat (2) @(negedge clock);
          if (!mon_nr) begin
            response = model_resp;
            enable_response = 1'b1;
            model_wait_ack(1'b0, 1'b1, mon_ok);
            if (model_mode == 2) begin
              for (int i = 0; i < 100; i++) begin
                @(negedge clock);
                if (busy === 1'b0) break;
              end
              mon_skip = 1'b1;
            end
            enable_response = 1'b0;
            if (!mon_skip) model_wait_ack(1'b0, 1'b0, mon_ok);
          end else begin
            enable_response = 1'b1;
            repeat (3) begin
              @(negedge clock);
              if (ack_response !== 1'b0) nr_ack_seen = 1'b1;
            end
            enable_response = 1'b0;
          end
          if (!mon_skip) begin
            enable_command_complete = 1'b1;
            command_complete = 1'b1;
            model_wait_ack(1'b1, 1'b1, mon_ok);
            enable_command_complete = 1'b0;
            command_complete = 1'b0;
            model_wait_ack(1'b1, 1'b0, mon_ok);
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (h_done === 1'b1 || d_done === 1'b1) begin
        mon_d.own_d = d_done;
        mon_d.err   = (d_done === 1'b1) ? d_err : h_err;
        mon_d.chk   = 1'b0;
        mon_d.resp  = resp_data;
        obs_done_q.push_back(mon_d);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench watchdog expired");
  end

  task automatic push_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic nr);
    cmd_t c;
    c.idx = idx; c.arg = arg; c.nr = nr;
    exp_cmd_q.push_back(c);
  endtask

  task automatic push_done(input logic own_d, input logic err, input logic chk, input logic [127:0] r);
    done_t d;
    d.own_d = own_d; d.err = err; d.chk = chk; d.resp = r;
    exp_done_q.push_back(d);
  endtask

  task automatic score_cmds(input string tag);
    cmd_t e, o;
    checks++;
    if (obs_cmd_q.size() != exp_cmd_q.size()) begin
      failures++;
      $display("FAIL %s_cmd_count got=%0d exp=%0d", tag, obs_cmd_q.size(), exp_cmd_q.size());
    end
    while (obs_cmd_q.size() > 0 && exp_cmd_q.size() > 0) begin
      o = obs_cmd_q.pop_front();
      e = exp_cmd_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL %s_cmd got idx=%0d arg=%h nr=%b exp idx=%0d arg=%h nr=%b",
                 tag, o.idx, o.arg, o.nr, e.idx, e.arg, e.nr);
      end
    end
    obs_cmd_q.delete();
    exp_cmd_q.delete();
  endtask

  task automatic score_done(input string tag);
    done_t e, o;
    checks++;
    if (obs_done_q.size() != exp_done_q.size()) begin
      failures++;
      $display("FAIL %s_done_count got=%0d exp=%0d", tag, obs_done_q.size(), exp_done_q.size());
    end
    while (obs_done_q.size() > 0 && exp_done_q.size() > 0) begin
      o = obs_done_q.pop_front();
      e = exp_done_q.pop_front();
      checks++;
      if ({o.own_d, o.err} !== {e.own_d, e.err}) begin
        failures++;
        $display("FAIL %s_done got own_d=%b err=%b exp own_d=%b err=%b", tag, o.own_d, o.err, e.own_d, e.err);
      end
      if (e.chk) begin
        checks++;
        if (o.resp !== e.resp) begin
          failures++;
          $display("FAIL %s_resp_data got=%h exp=%h", tag, o.resp, e.resp);
        end
      end
    end
    obs_done_q.delete();
    exp_done_q.delete();
  endtask

  task automatic wait_done(input bit own_d, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if ((own_d ? d_done : h_done) === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s_done_wait got=no_pulse exp=pulse", tag);
    end
    if (own_d) d_req = 1'b0; else h_req = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({h_done, h_err, d_done, d_err, busy, new_command, timeout_enable, no_response,
         ack_response, ack_command_complete, cmd_index, cmd_argument, resp_data} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b nc=%b te=%b idx=%0d arg=%h resp=%h exp=all_zero",
               busy, new_command, timeout_enable, cmd_index, cmd_argument, resp_data);
    end
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle_busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_single_read(input string tag);
    int lat = 0;
    model_mode = 0;
    model_resp = RESP_900;
    push_cmd(6'd17, 32'h0000_0200, 1'b0);
    push_done(1'b0, 1'b0, 1'b1, RESP_900);
    h_index = 6'd17; h_arg = 32'h0000_0200; h_app = 1'b0; h_no_resp = 1'b0;
    h_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      lat++;
      if (new_command === 1'b1) break;
    end
    checks++;
    if (lat != 2) begin
      failures++;
      $display("FAIL %s_latency got=%0d exp=2", tag, lat);
    end
    wait_done(1'b0, tag);
    @(negedge clock);
    checks++;
    if ({busy, timeout_enable} !== 2'b00) begin
      failures++;
      $display("FAIL %s_idle_after got busy=%b te=%b exp=0,0", tag, busy, timeout_enable);
    end
    score_cmds(tag);
    score_done(tag);
  endtask

  task automatic test_back_to_back;
    model_mode = 0;
    model_resp = RESP_900;
    push_cmd(CMD12_INDEX, 32'h0000_0000, 1'b0);
    push_cmd(6'd13, 32'h1234_0000, 1'b0);
    push_done(1'b1, 1'b0, 1'b1, RESP_900);
    push_done(1'b0, 1'b0, 1'b1, RESP_900);
    d_index = CMD12_INDEX; d_arg = 32'h0; d_no_resp = 1'b0;
    h_index = 6'd13; h_arg = 32'h1234_0000; h_app = 1'b0; h_no_resp = 1'b0;
    d_req = 1'b1;
    h_req = 1'b1;
    wait_done(1'b1, "arb_d");
    wait_done(1'b0, "arb_h");
    repeat (2) @(negedge clock);
    score_cmds("arb");
    score_done("arb");
  endtask

  task automatic test_acmd(input bit app_ok);
    string tag;
    tag = app_ok ? "acmd_ok" : "acmd_rej";
    model_mode = 0;
    model_resp = app_ok ? RESP_920 : RESP_900;
    rca = 16'h1234;
    push_cmd(CMD55_INDEX, 32'h1234_0000, 1'b0);
    if (app_ok) push_cmd(6'd41, 32'h40FF_8000, 1'b0);
    push_done(1'b0, !app_ok, 1'b1, app_ok ? RESP_920 : RESP_900);
    h_index = 6'd41; h_arg = 32'h40FF_8000; h_app = 1'b1; h_no_resp = 1'b0;
    h_req = 1'b1;
    wait_done(1'b0, tag);
    h_app = 1'b0;
    repeat (6) @(negedge clock);
    score_cmds(tag);
    score_done(tag);
  endtask

  task automatic test_no_resp;
    model_mode = 0;
    push_cmd(6'd0, 32'h0, 1'b1);
    push_done(1'b0, 1'b0, 1'b0, '0);
    h_index = 6'd0; h_arg = 32'h0; h_app = 1'b0; h_no_resp = 1'b1;
    h_req = 1'b1;
    wait_done(1'b0, "noresp");
    h_no_resp = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (nr_ack_seen !== 1'b0) begin
      failures++;
      $display("FAIL noresp_ack_response got=%b exp=0", nr_ack_seen);
    end
    score_cmds("noresp");
    score_done("noresp");
  endtask

  task automatic test_timeout;
    int cyc = 0, first = 0, pulses = 0, span = -1;
    bit seen = 1'b0;
    model_mode = 1;
    for (int i = 0; i < EXP_PULSES; i++) push_cmd(6'd8, 32'h0000_01AA, 1'b0);
    push_done(1'b0, 1'b1, 1'b0, '0);
    h_index = 6'd8; h_arg = 32'h0000_01AA; h_app = 1'b0; h_no_resp = 1'b0;
    h_req = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      cyc++;
      if (new_command === 1'b1) begin
        pulses++;
        if (pulses == 1) first = cyc;
      end
      if (h_done === 1'b1) begin
        seen = 1'b1;
        span = cyc - first;
        break;
      end
    end
    h_req = 1'b0;
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL timeout_done_wait got=no_pulse exp=pulse");
    end
    checks++;
    if (pulses != EXP_PULSES) begin
      failures++;
      $display("FAIL timeout_pulses got=%0d exp=%0d", pulses, EXP_PULSES);
    end
    checks++;
    if (span < EXP_SPAN - 1 || span > EXP_SPAN + 1) begin
      failures++;
      $display("FAIL timeout_span got=%0d exp=%0d", span, EXP_SPAN);
    end
    repeat (2) @(negedge clock);
    model_mode = 0;
    score_cmds("timeout");
    score_done("timeout");
  endtask

  task automatic test_reset_in_rack;
    bit seen = 1'b0;
    model_mode = 2;
    model_resp = RESP_920;
    push_cmd(6'd17, 32'h0000_0400, 1'b0);
    h_index = 6'd17; h_arg = 32'h0000_0400; h_app = 1'b0; h_no_resp = 1'b0;
    h_req = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (ack_response === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL rack_reach got=no_ack exp=ack");
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({h_done, h_err, d_done, d_err, busy, new_command, timeout_enable, no_response,
         ack_response, ack_command_complete, cmd_index, cmd_argument, resp_data} !== '0) begin
      failures++;
      $display("FAIL rack_reset_outputs got busy=%b ack=%b te=%b idx=%0d resp=%h exp=all_zero",
               busy, ack_response, timeout_enable, cmd_index, resp_data);
    end
    reset = 1'b1;
    h_req = 1'b0;
    repeat (8) @(negedge clock);
    model_mode = 0;
    score_cmds("rack_reset");
    score_done("rack_reset");
  endtask

  initial begin
    reset = 1'b0;
    h_req = 1'b0; h_index = '0; h_arg = '0; h_app = 1'b0; h_no_resp = 1'b0;
    d_req = 1'b0; d_index = '0; d_arg = '0; d_no_resp = 1'b0;
    rca = 16'h1234;
    test_reset();
    test_single_read("read");
    test_back_to_back();
    test_acmd(1'b1);
    test_acmd(1'b0);
    test_no_resp();
    test_timeout();
    test_reset_in_rack();
    test_single_read("read_after_reset");
    checks++;
    if (model_fault != 0) begin
      failures++;
      $display("FAIL model_handshake got=%0d exp=0", model_fault);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sd_cmd_sequencer.md
Name: sd_cmd_sequencer

Overview:
- Controller in front of the SD host CMD block; the sole driver of that block's command inputs.
- Arbitrates between two requesters: host register interface (H) and data-transfer engine (D, e.g. CMD12 stop).
- Inserts the CMD55 prefix for application commands (ACMD).
- Runs the enable/ack handshakes, captures the response and reports done/error per requester with its own timeout watchdog.

Parameters:
- TIMEOUT_CYCLES, 4096, clock cycles allowed from new_command to completion before error.
- RETRY_MAX, 2, reissue count on timeout; used only with SD_CMD_RETRY_EN.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- h_req  in  1  host request; held with fields stable until h_done
- h_index  in  6  host command index
- h_arg  in  32  host argument
- h_app  in  1  1 = ACMD, send CMD55 first
- h_no_resp  in  1  command expects no response
- h_done  out  1  one-cycle completion pulse to host
- h_err  out  1  valid with h_done; 1 = timeout or APP_CMD failure
- d_req, d_index, d_arg, d_no_resp  in  1/6/32/1  data-engine request; same rules as host, no ACMD
- d_done, d_err  out  1/1  data-engine completion pulse and error flag
- rca  in  16  card RCA used in the CMD55 argument
- resp_data  out  128  last captured response; valid from done pulse until the next capture
- busy  out  1  state != IDLE
- new_command  out  1  one-cycle pulse to the CMD block
- cmd_index  out  6  to the CMD block
- cmd_argument  out  32  to the CMD block
- timeout_enable  out  1  held high while a command is outstanding
- no_response  out  1  to the CMD block; response phase skipped
- response  in  128  from the CMD block
- enable_response  in  1  response valid
- ack_response  out  1  acknowledges enable_response
- command_complete  in  1  completion level from the CMD block
- enable_command_complete  in  1  completion handshake request
- ack_command_complete  out  1  acknowledges enable_command_complete

Behaviour:
- Reset (reset=0 at a clock edge): every output 0, state IDLE, retry count 0. Applies mid-operation: the in-flight command is dropped with no done pulse.
- IDLE: when d_req or h_req is high, latch the winner's index, arg and no_resp; go to ISSUE the next cycle.
  - D has fixed priority over H; on simultaneous requests D is served first and H waits.
  - If the winner is H with h_app=1, latch the pair: CMD55 first, argument {rca,16'h0}, with a response required.
- ISSUE: drive cmd_index, cmd_argument, no_response and timeout_enable=1; pulse new_command for exactly 1 cycle; clear the timer; go to WAIT.
- WAIT: the timer increments every cycle.
  - If no_response=0 and enable_response=1: resp_data <= response, ack_response <= 1, go to RACK.
  - If no_response=1, enable_response is ignored and WAIT looks only for enable_command_complete.
  - When enable_command_complete=1 and the response phase is done or skipped: ack_command_complete <= 1, go to CACK.
  - When the timer reaches TIMEOUT_CYCLES-1: go to FINISH with err=1.
- RACK: hold ack_response until enable_response=0, then drop it and return to WAIT. The timer keeps running.
- CACK: hold ack_command_complete until enable_command_complete=0, then drop it and go to NEXT.
- NEXT:
  - If the CMD55 stage just finished and resp_data[5] (APP_CMD) = 1: load the real ACMD fields and go to ISSUE. The ACMD pair is atomic; D cannot pre-empt between CMD55 and the ACMD.
  - If resp_data[5] = 0: go to FINISH with err=1.
  - Otherwise go to FINISH with err=0.
- FINISH: pulse the owner's done for 1 cycle with err valid; drop timeout_enable; go to IDLE. A new request is accepted no earlier than the cycle after FINISH.
- Minimum latency from req to new_command: 2 cycles.
- A requester dropping req before done is illegal; behaviour is undefined and the bench must not drive it.

Optional Feature:
- Macro: SD_CMD_RETRY_EN.
- Enabled: a timeout in WAIT returns to ISSUE with the same command, up to RETRY_MAX times.
  - For an ACMD, a retry of either stage restarts at CMD55.
  - err is set only after RETRY_MAX+1 total timeouts.
  - The retry counter clears at FINISH.
- Disabled: the first timeout goes straight to FINISH with err=1, and RETRY_MAX is unused.

Decomposition:
- Package sd_cmd_pkg holds:
  - state encoding (IDLE, ISSUE, WAIT, RACK, CACK, NEXT, FINISH);
  - CMD55_INDEX=6'd55 and CMD12_INDEX=6'd12;
  - APP_CMD_BIT=5;
  - owner encoding OWN_H/OWN_D.
- One sub-module, sd_cmd_timer: clear/enable counter with a terminal-count flag at TIMEOUT_CYCLES-1.

Test Plan:
- H: CMD17, arg 32'h0000_0200, no_resp=0. The model returns response 128'h...0900 and completes. Required: one new_command pulse with index 17, resp_data captured, h_done=1 with h_err=0.
- H and D request in the same cycle (D CMD12, H CMD13). Required: CMD12 issued first and d_done fires; CMD13 new_command follows; H is never served first.
- H ACMD41, rca=16'h1234. Required:
  - first command is index 55 with arg 32'h1234_0000;
  - with response bit5=1, the second command is index 41;
  - with bit5=0, only CMD55 is issued and h_err=1.
- H CMD0 with no_resp=1. Required: enable_response ignored, ack_response stays 0, completion-only path, h_done with h_err=0.
- TIMEOUT_CYCLES=16 and the model never completes. Required:
  - without the macro: h_err=1 at about 16 cycles after new_command;
  - with SD_CMD_RETRY_EN and RETRY_MAX=2: 3 new_command pulses, then h_err=1.
- Assert reset=0 during RACK. Required: all outputs 0 next cycle, no done pulse; a fresh request afterwards completes normally.
